// File: rtl/syn_fifo.sv
// Single-clock parametrised FIFO with optional first-word-fall-through read,
// programmable almost-full/almost-empty thresholds, occupancy count and error pulses.
module syn_fifo #(
  parameter int ADDR_WIDTH    = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  winc,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rinc,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_ZERO   = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0]   CNT_DEPTH  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   CNT_AFULL  = AFULL_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   CNT_AEMPTY = AEMPTY_THRESH[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH-1:0] r_rptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_full;
  logic                  r_afull;
  logic                  r_empty;
  logic                  r_aempty;
  logic                  r_ovf;
  logic                  r_udf;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_wr_ok;
  logic                  w_rd_ok;
  logic [ADDR_WIDTH:0]   w_count_nxt;

  // Acceptance is judged on the flags registered at the start of the cycle.
  always_comb begin
    w_wr_ok = winc & ~r_full;
    w_rd_ok = rinc & ~r_empty;
    case ({w_wr_ok, w_rd_ok})
      2'b10:   w_count_nxt = r_count + CNT_ONE;
      2'b01:   w_count_nxt = r_count - CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage array: not reset, but a write during reset is suppressed.
  always_ff @(posedge clk) begin
    if (rst_n && w_wr_ok) begin
      r_mem[r_wptr] <= wdata;
    end
  end

  // Pointers, occupancy, flags derived from the next count, error pulses and read register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr   <= {ADDR_WIDTH{1'b0}};
      r_rptr   <= {ADDR_WIDTH{1'b0}};
      r_count  <= CNT_ZERO;
      r_full   <= 1'b0;
      r_afull  <= 1'b0;
      r_empty  <= 1'b1;
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
      r_rdata  <= {DATA_WIDTH{1'b0}};
    end else begin
      if (w_wr_ok) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_rd_ok) begin
        r_rptr  <= r_rptr + PTR_ONE;
        r_rdata <= r_mem[r_rptr];
      end
      r_count  <= w_count_nxt;
      r_full   <= (w_count_nxt == CNT_DEPTH);
      r_afull  <= (w_count_nxt >= CNT_AFULL);
      r_empty  <= (w_count_nxt == CNT_ZERO);
      r_aempty <= (w_count_nxt <= CNT_AEMPTY);
      r_ovf    <= winc & r_full;
      r_udf    <= rinc & r_empty;
    end
  end

  // In FWFT mode the head word is presented directly; the register covers the empty case.
  generate
    if (FWFT != 0) begin : g_fwft
      assign rdata = r_empty ? r_rdata : r_mem[r_rptr];
    end else begin : g_std
      assign rdata = r_rdata;
    end
  endgenerate

  assign full         = r_full;
  assign almost_full  = r_afull;
  assign empty        = r_empty;
  assign almost_empty = r_aempty;
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

endmodule

// File: tb/tb_syn_fifo.sv
// Randomised and directed bench for syn_fifo: one standard-read and one FWFT instance
// share stimulus and are compared every cycle against a queue-based model.
module tb_syn_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        winc;
  logic [31:0] wdata;
  logic        rinc;

  logic        full0, afull0, empty0, aempty0, ovf0, udf0;
  logic [31:0] rdata0;
  logic [4:0]  count0;
  logic        full1, afull1, empty1, aempty1, ovf1, udf1;
  logic [31:0] rdata1;
  logic [4:0]  count1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model state
  logic [31:0] q[$];
  logic        m_ovf = 1'b0;
  logic        m_udf = 1'b0;
  logic [31:0] m_rd0 = 32'h0;

  always #5 clk = ~clk;

  syn_fifo #(.FWFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .full(full0),
    .almost_full(afull0), .rinc(rinc), .rdata(rdata0), .empty(empty0),
    .almost_empty(aempty0), .count(count0), .overflow(ovf0), .underflow(udf0)
  );

  syn_fifo #(.FWFT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .full(full1),
    .almost_full(afull1), .rinc(rinc), .rdata(rdata1), .empty(empty1),
    .almost_empty(aempty1), .count(count1), .overflow(ovf1), .underflow(udf1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, advance the model at the edge, return at the falling edge.
  task automatic step(input logic w, input logic [31:0] d, input logic r, input logic rs);
    logic was_full, was_empty;
    winc  = w;
    wdata = d;
    rinc  = r;
    rst_n = rs;
    @(posedge clk);
    if (!rs) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      m_rd0 = 32'h0;
    end else begin
      was_full  = (q.size() == 16);
      was_empty = (q.size() == 0);
      m_ovf = w && was_full;
      m_udf = r && was_empty;
      if (r && !was_empty) begin
        m_rd0 = q.pop_front();
      end
      if (w && !was_full) begin
        q.push_back(d);
      end
    end
    @(negedge clk);
  endtask

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("count0", 32'(count0), 32'(q.size()));
      chk("count1", 32'(count1), 32'(q.size()));
      chk("empty0", 32'(empty0), 32'(q.size() == 0));
      chk("empty1", 32'(empty1), 32'(q.size() == 0));
      chk("full0", 32'(full0), 32'(q.size() == 16));
      chk("full1", 32'(full1), 32'(q.size() == 16));
      chk("afull0", 32'(afull0), 32'(q.size() >= 14));
      chk("afull1", 32'(afull1), 32'(q.size() >= 14));
      chk("aempty0", 32'(aempty0), 32'(q.size() <= 2));
      chk("aempty1", 32'(aempty1), 32'(q.size() <= 2));
      chk("ovf0", 32'(ovf0), 32'(m_ovf));
      chk("ovf1", 32'(ovf1), 32'(m_ovf));
      chk("udf0", 32'(udf0), 32'(m_udf));
      chk("udf1", 32'(udf1), 32'(m_udf));
      chk("rdata0", rdata0, m_rd0);
      if (q.size() != 0) begin
        chk("rdata1_head", rdata1, q[0]);
      end
    end
  end

  initial begin
    winc = 1'b0; wdata = 32'h0; rinc = 1'b0; rst_n = 1'b0;
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h1234, 1'b1, 1'b0);
    chk_en = 1'b1;
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("lit_reset_count", 32'(count0), 32'd0);
    chk("lit_reset_empty", 32'(empty0), 32'd1);
    chk("lit_reset_aempty", 32'(aempty1), 32'd1);
    chk("lit_reset_rdata", rdata0, 32'd0);

    // Fill with 0..15, then one dropped write
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 32'(i), 1'b0, 1'b1);
      if (i == 13) chk("lit_afull_at14", 32'(afull0), 32'd1);
    end
    chk("lit_fill_count", 32'(count0), 32'd16);
    chk("lit_fill_full", 32'(full1), 32'd1);
    step(1'b1, 32'hDEAD, 1'b0, 1'b1);
    chk("lit_ovf_pulse", 32'(ovf0), 32'd1);
    chk("lit_ovf_count", 32'(count0), 32'd16);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("lit_ovf_clear", 32'(ovf0), 32'd0);

    // Drain in order, then one rejected read
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b1);
      chk("lit_drain_rdata", rdata0, 32'(i));
    end
    chk("lit_drain_empty", 32'(empty0), 32'd1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("lit_udf_pulse", 32'(udf0), 32'd1);
    chk("lit_udf_hold", rdata0, 32'hF);

    // Wrap-around
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 10; i++) step(1'b1, $urandom, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
      chk("lit_wrap_count", 32'(count0), 32'd0);
    end

    // Simultaneous at count 5
    for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, $urandom, 1'b1, 1'b1);
    chk("lit_both_count5", 32'(count0), 32'd5);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

    // Simultaneous at empty: write wins, underflow pulses
    step(1'b1, 32'h55, 1'b1, 1'b1);
    chk("lit_both_empty_count", 32'(count0), 32'd1);
    chk("lit_both_empty_udf", 32'(udf0), 32'd1);

    // Simultaneous at full: read wins, overflow pulses
    for (int i = 0; i < 15; i++) step(1'b1, $urandom, 1'b0, 1'b1);
    step(1'b1, 32'h77, 1'b1, 1'b1);
    chk("lit_both_full_count", 32'(count1), 32'd15);
    chk("lit_both_full_ovf", 32'(ovf1), 32'd1);
    for (int i = 0; i < 15; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

    // FWFT fall-through
    step(1'b1, 32'hA5, 1'b0, 1'b1);
    chk("lit_fwft_empty", 32'(empty1), 32'd0);
    chk("lit_fwft_rdata", rdata1, 32'hA5);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("lit_fwft_pop_empty", 32'(empty1), 32'd1);

    // Reset mid-operation with a concurrent write
    for (int i = 0; i < 9; i++) step(1'b1, $urandom, 1'b0, 1'b1);
    chk("lit_pre_reset_count", 32'(count0), 32'd9);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'hBEEF, 1'b0, 1'b0);
    chk("lit_mid_reset_count", 32'(count0), 32'd0);
    chk("lit_mid_reset_empty", 32'(empty1), 32'd1);
    chk("lit_mid_reset_rdata", rdata0, 32'd0);

    // Random traffic with shifting write/read bias
    for (int i = 0; i < 3000; i++) begin
      int bias;
      bias = (i / 300) % 3;
      step(($urandom_range(0, 9) < ((bias == 0) ? 7 : (bias == 1) ? 3 : 5)),
           $urandom,
           ($urandom_range(0, 9) < ((bias == 0) ? 3 : (bias == 1) ? 7 : 5)),
           ($urandom_range(0, 499) != 0));
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
